sobel_stream: RTL and testbench
===============================

SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 Parameter PIX_W, default 8: input pixel width in bits.
REQ-002 Parameter IMG_W, default 640: pixels per line, minimum 3.
REQ-003 Parameter IMG_H, default 480: lines per frame, minimum 3.
REQ-004 Parameter OUT_W, default 16: gradient output width in bits.
REQ-005 Port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-low.
REQ-007 Port in_valid, input, 1: in_pix is valid this cycle.
REQ-008 Port in_sof, input, 1: qualifies in_valid as the first pixel of a frame.
REQ-009 Port in_pix, input, PIX_W: raster-order pixel.
REQ-010 Port mode, input, 1: 0 selects |gx|+|gy|; 1 selects max(|gx|,|gy|).
REQ-011 Port out_valid, output, 1: gradient is valid.
REQ-012 Port out_eof, output, 1: qualifies the last interior gradient of a frame.
REQ-013 Port gradient, output, OUT_W: gradient magnitude.

Function
REQ-014 The module SHALL keep two line buffers of IMG_W x PIX_W and a 3x3 window, labelled a0 a1 a2 / a7 c a3 / a6 a5 a4.
REQ-015 The module SHALL track column and row counters, advanced only on in_valid and wrapping at IMG_W-1 and IMG_H-1 respectively.
REQ-016 in_sof with in_valid SHALL force the counters to (row 0, col 0) for that pixel, regardless of their prior state.
REQ-017 gx SHALL be (a0+2a1+a2)-(a6+2a5+a4) and gy SHALL be (a2+2a3+a4)-(a0+2a7+a6), both signed PIX_W+3 bits, with no overflow.
REQ-018 Magnitude SHALL be |gx|+|gy| (mode 0) or max(|gx|,|gy|) (mode 1), computed at PIX_W+4 bits, then saturated to 2^OUT_W-1 when OUT_W is narrower.
REQ-019 Only interior pixels (row 1..IMG_H-2, col 1..IMG_W-2) SHALL produce output, giving exactly (IMG_W-2)*(IMG_H-2) out_valid pulses per frame.
REQ-020 The gradient for centre (r,c) SHALL assert out_valid exactly 4 cycles after the cycle that accepts input (r+1,c+1).
REQ-021 Pipeline stages: window latch; gx/gy; absolute values; combine and saturate.
REQ-022 The pipeline SHALL advance every cycle, with no stall and no backpressure.
REQ-023 Gaps in in_valid SHALL NOT change the result or per-pixel latency.
REQ-024 mode SHALL be sampled at stage 3, alongside the absolute values.
REQ-025 out_eof SHALL assert together with the out_valid for centre (IMG_H-2, IMG_W-2).
REQ-026 gradient SHALL hold its last value while out_valid is low.

Reset
REQ-027 While rst=0: out_valid=0, out_eof=0, gradient=0, counters=0, and the valid pipeline is cleared; line-buffer contents are don't-care.
REQ-028 Reset asserted mid-frame SHALL drop all in-flight results (no out_valid on the following cycle).
REQ-029 After reset is released, output SHALL resume only after an in_sof.

Configuration
REQ-030 With SOBEL_THRESH_EN defined, the module SHALL add input thresh (OUT_W bits) and output edge (1 bit).
REQ-031 With SOBEL_THRESH_EN defined, edge SHALL be 1 when the saturated gradient >= thresh, SHALL be registered with gradient, and SHALL reset to 0.
REQ-032 Without SOBEL_THRESH_EN, neither port nor the comparator SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-033 Shared package sobel_pkg SHALL hold the width helpers (GRAD_W = PIX_W+4) and the mode encodings (MODE_SUM=0, MODE_MAX=1).
REQ-034 The line buffers SHALL be one sub-module, sobel_linebuf (dual-row shift storage, IMG_W deep), instantiated once.

Verification (PIX_W=8, IMG_W=8, IMG_H=6, OUT_W=16 unless stated)
REQ-035 Constant frame of value 77 -> 24 out_valid pulses, all gradient=0, out_eof on the 24th pulse.
REQ-036 Vertical step, cols 0-3 = 0 and cols 4-7 = 255 -> gradient=1020 at cols 3 and 4, 0 elsewhere, identical in mode 0 and mode 1; OUT_W=8 -> 255 (saturated).
REQ-037 Single pixel 255 at (2,2), rest 0 -> centre (1,1) gives 510 in mode 0 and 255 in mode 1.
REQ-038 Random in_valid gaps (50% duty) on the step frame -> same 24 values, each exactly 4 cycles after its triggering input.
REQ-039 rst=0 at row 3 mid-frame -> out_valid=0 the next cycle; after release and a fresh in_sof, the full frame matches REQ-036.
REQ-040 SOBEL_THRESH_EN defined, thresh=600, step frame -> edge=1 only at cols 3 and 4.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared width helper and magnitude-mode encodings for the sobel_stream block.
package sobel_pkg;

  typedef enum logic {
    MODE_SUM = 1'b0,
    MODE_MAX = 1'b1
  } mode_e;

  // Magnitude width: |gx|+|gy| of two PIX_W+3 signed gradients never exceeds PIX_W+4 bits.
  function automatic int grad_w(input int pix_w);
    return pix_w + 4;
  endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// Two chained line-length shift rows; taps give the pixel one and two lines above the input.
module sobel_linebuf #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640
) (
  input  logic             clk,
  input  logic             en,
  input  logic [PIX_W-1:0] pix,
  output logic [PIX_W-1:0] up1,
  output logic [PIX_W-1:0] up2
);

  logic [IMG_W-1:0][PIX_W-1:0] row1_q, row1_d, row0_q, row0_d;

  always_comb begin
    row1_d = row1_q;
    row0_d = row0_q;
    if (en) begin
      row1_d = {row1_q[IMG_W-2:0], pix};
      row0_d = {row0_q[IMG_W-2:0], row1_q[IMG_W-1]};
    end
  end

  // Contents are meaningless until two lines of a fresh frame have been pushed; no reset needed.
  always_ff @(posedge clk) begin
    row1_q <= row1_d;
    row0_q <= row0_d;
  end

  assign up1 = row1_q[IMG_W-1];
  assign up2 = row0_q[IMG_W-1];

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel gradient magnitude, 4-stage pipeline, no backpressure.
// Optional threshold output enabled by defining SOBEL_THRESH_EN.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             mode,
  output logic             out_valid,
  output logic             out_eof,
  output logic [OUT_W-1:0] gradient
`ifdef SOBEL_THRESH_EN
  ,
  input  logic [OUT_W-1:0] thresh,
  // "edge" is a reserved word, hence the suffix.
  output logic             edge_flag
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SW = PIX_W + 3;
  localparam int GW = grad_w(PIX_W);
  localparam int STAGES = 3;

  logic [PIX_W-1:0] up1, up2;

  sobel_linebuf #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_linebuf (
    .clk (clk),
    .en  (in_valid),
    .pix (in_pix),
    .up1 (up1),
    .up2 (up2)
  );

  // Control: frame position, valid/eof shift registers and registered outputs.
  logic [CW-1:0]     col_q, col_d, col_cur;
  logic [RW-1:0]     row_q, row_d, row_cur;
  logic              act_q, act_d;
  logic [STAGES:0]   vld_pipe_q, vld_pipe_d, eof_pipe_q, eof_pipe_d;
  logic [OUT_W-1:0]  gradient_q, gradient_d, sat;
  logic              s1_vld, s1_eof;

  always_comb begin
    col_cur = in_sof ? '0 : col_q;
    row_cur = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    act_d   = act_q | (in_valid & in_sof);
    if (in_valid) begin
      if (col_cur == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_cur == RW'(IMG_H - 1)) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end
    // The pixel at (r,c) completes the window centred on (r-1,c-1).
    s1_vld = in_valid & (act_q | in_sof) & (row_cur >= RW'(2)) & (col_cur >= CW'(2));
    s1_eof = s1_vld & (row_cur == RW'(IMG_H - 1)) & (col_cur == CW'(IMG_W - 1));
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], s1_vld};
    eof_pipe_d = {eof_pipe_q[STAGES-1:0], s1_eof};
    gradient_d = vld_pipe_q[STAGES-1] ? sat : gradient_q;
  end

`ifdef SOBEL_THRESH_EN
  logic edge_q, edge_d;
  always_comb edge_d = vld_pipe_q[STAGES-1] ? (sat >= thresh) : edge_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q      <= '0;
      row_q      <= '0;
      act_q      <= 1'b0;
      vld_pipe_q <= '0;
      eof_pipe_q <= '0;
      gradient_q <= '0;
`ifdef SOBEL_THRESH_EN
      edge_q     <= 1'b0;
`endif
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      act_q      <= act_d;
      vld_pipe_q <= vld_pipe_d;
      eof_pipe_q <= eof_pipe_d;
      gradient_q <= gradient_d;
`ifdef SOBEL_THRESH_EN
      edge_q     <= edge_d;
`endif
    end
  end

  // Datapath: window (a0..a7 around, index 8 = centre), gx/gy, abs, combine.
  logic [8:0][PIX_W-1:0] win_q, win_d;
  logic signed [SW-1:0]  gx_q, gx_d, gy_q, gy_d;
  logic [SW-1:0]         agx_q, agx_d, agy_q, agy_d;
  mode_e                 mode_q, mode_d;
  logic [GW-1:0]         mag;

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      win_d[0] = win_q[1]; win_d[1] = win_q[2]; win_d[2] = up2;
      win_d[7] = win_q[8]; win_d[8] = win_q[3]; win_d[3] = up1;
      win_d[6] = win_q[5]; win_d[5] = win_q[4]; win_d[4] = in_pix;
    end
    gx_d = (ext(win_q[0]) + (ext(win_q[1]) <<< 1) + ext(win_q[2]))
         - (ext(win_q[6]) + (ext(win_q[5]) <<< 1) + ext(win_q[4]));
    gy_d = (ext(win_q[2]) + (ext(win_q[3]) <<< 1) + ext(win_q[4]))
         - (ext(win_q[0]) + (ext(win_q[7]) <<< 1) + ext(win_q[6]));
    agx_d  = gx_q[SW-1] ? SW'(-gx_q) : SW'(gx_q);
    agy_d  = gy_q[SW-1] ? SW'(-gy_q) : SW'(gy_q);
    mode_d = mode_e'(mode);
    if (mode_q == MODE_MAX) mag = (agx_q > agy_q) ? GW'(agx_q) : GW'(agy_q);
    else                    mag = GW'(agx_q) + GW'(agy_q);
  end

  generate
    if (OUT_W < GW) begin : g_sat
      assign sat = (|mag[GW-1:OUT_W]) ? '1 : mag[OUT_W-1:0];
    end else begin : g_ext
      assign sat = OUT_W'(mag);
    end
  endgenerate

  always_ff @(posedge clk) begin
    win_q  <= win_d;
    gx_q   <= gx_d;
    gy_q   <= gy_d;
    agx_q  <= agx_d;
    agy_q  <= agy_d;
    mode_q <= mode_d;
  end

  assign out_valid = vld_pipe_q[STAGES];
  assign out_eof   = eof_pipe_q[STAGES];
  assign gradient  = gradient_q;
`ifdef SOBEL_THRESH_EN
  assign edge_flag = edge_q;
`endif

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream: reference Sobel model on a stored frame, decoupled monitor.
module tb_sobel_stream;
  localparam int PIX_W = 8, IMG_W = 8, IMG_H = 6, OUT_W = 16;

  logic clk = 1'b0;
  logic rst, in_valid, in_sof, mode;
  logic [PIX_W-1:0] in_pix;
  logic out_valid, out_eof, out_valid8, out_eof8;
  logic [OUT_W-1:0] gradient;
  logic [7:0] gradient8;
`ifdef SOBEL_THRESH_EN
  logic [OUT_W-1:0] thresh = 16'd600;
  logic [7:0] thresh8 = 8'd200;
  logic edge_flag, edge_flag8;
`endif

  always #5 clk = ~clk;

  sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix), .mode(mode),
    .out_valid(out_valid), .out_eof(out_eof), .gradient(gradient)
`ifdef SOBEL_THRESH_EN
    , .thresh(thresh), .edge_flag(edge_flag)
`endif
  );

  sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix), .mode(mode),
    .out_valid(out_valid8), .out_eof(out_eof8), .gradient(gradient8)
`ifdef SOBEL_THRESH_EN
    , .thresh(thresh8), .edge_flag(edge_flag8)
`endif
  );

  typedef struct { int val; bit eof; int due; } exp_t;
  exp_t sb[$];
  int img[IMG_H][IMG_W];
  int tests = 0, fails = 0, cyc = 0, npulse = 0, neof = 0;
  int last_g = 0, last_g8 = 0;
  logic rst_s = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Sobel magnitude straight from the kernel definition over the stored frame.
  function automatic int ref_grad(input int r, input int c, input bit m);
    int gx, gy, ax, ay;
    gx = (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1])
       - (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1]);
    gy = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    ax = iabs(gx);
    ay = iabs(gy);
    return m ? ((ax > ay) ? ax : ay) : ax + ay;
  endfunction

  task automatic fill(input int kind);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        case (kind)
          0: img[r][c] = 77;
          1: img[r][c] = (c >= 4) ? 255 : 0;
          2: img[r][c] = (r == 2 && c == 2) ? 255 : 0;
          default: img[r][c] = int'($urandom_range(255, 0));
        endcase
  endtask

  task automatic send(input int r, input int c, input bit sof, input bit gap, input bit expect_out);
    if (gap) repeat ($urandom_range(2, 0)) begin
      in_valid = 1'b0;
      in_sof   = 1'($urandom_range(1, 0));
      in_pix   = 8'($urandom_range(255, 0));
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_sof   = sof;
    in_pix   = 8'(img[r][c]);
    if (expect_out && r >= 2 && c >= 2)
      sb.push_back('{val: ref_grad(r-1, c-1, mode), eof: (r == IMG_H-1 && c == IMG_W-1), due: cyc + 4});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic frame(input int kind, input bit m, input bit gap);
    fill(kind);
    mode   = m;
    npulse = 0;
    neof   = 0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        send(r, c, r == 0 && c == 0, gap, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("drain_left", sb.size(), 0);
    chk("pulse_count", npulse, (IMG_W-2)*(IMG_H-2));
    chk("eof_count", neof, 1);
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_s) begin
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_eof", int'(out_eof), 0);
      chk("rst_grad", int'(gradient), 0);
      last_g  = 0;
      last_g8 = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", int'(out_valid), 0);
      else begin
        e = sb.pop_front();
        chk("grad", int'(gradient), e.val);
        chk("grad_sat8", int'(gradient8), (e.val > 255) ? 255 : e.val);
        chk("valid8", int'(out_valid8), 1);
        chk("eof", int'(out_eof), int'(e.eof));
        chk("latency", cyc, e.due);
`ifdef SOBEL_THRESH_EN
        chk("edge", int'(edge_flag), int'(e.val >= 600));
`endif
        last_g  = e.val;
        last_g8 = (e.val > 255) ? 255 : e.val;
        npulse++;
        if (out_eof) neof++;
      end
    end else begin
      chk("hold", int'(gradient), last_g);
      chk("hold8", int'(gradient8), last_g8);
      chk("eof_idle", int'(out_eof), 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    frame(0, 1'b0, 1'b0);   // flat field
    frame(1, 1'b0, 1'b0);   // vertical step, sum
    frame(1, 1'b1, 1'b0);   // vertical step, max
    frame(1, 1'b0, 1'b1);   // step with input gaps
    frame(2, 1'b0, 1'b0);   // single bright pixel, sum
    frame(2, 1'b1, 1'b0);   // single bright pixel, max
    for (int k = 0; k < 3; k++) frame(3, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));

    // Mid-frame reset at row 3, then pixels without a start-of-frame, then a clean frame.
    fill(1);
    mode = 1'b0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        if (r < 3 || (r == 3 && c < 3)) send(r, c, r == 0 && c == 0, 1'b0, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        send(r, c, 1'b0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    frame(1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
